// File: rtl/uart_tx_pkg.sv
// Shared UART constants: FSM state encodings reused by the transmitter and the future receiver.
package uart_tx_pkg;

  localparam logic [2:0] UART_ST_IDLE  = 3'd0;
  localparam logic [2:0] UART_ST_ARMED = 3'd1;
  localparam logic [2:0] UART_ST_START = 3'd2;
  localparam logic [2:0] UART_ST_DATA  = 3'd3;
  localparam logic [2:0] UART_ST_STOP  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = UART_ST_IDLE,
    ST_ARMED = UART_ST_ARMED,
    ST_START = UART_ST_START,
    ST_DATA  = UART_ST_DATA,
    ST_STOP  = UART_ST_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_rise_detect.sv
// Rising-edge detector: one-clk pulse per low-to-high transition of level_i.
// The history register tracks the input even through reset, so a level that is
// already high when reset releases never produces a pulse.
module rise_detect (
  input  logic clk,
  input  logic level_i,
  output logic pulse_o
);

  logic level_q;

  always_ff @(posedge clk) begin
    level_q <= level_i;
  end

  assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a word in IDLE, then sends start, LSB-first data and
// stop bits, each lasting one baud interval (one rising edge of baud_in).
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_in,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_e            state_q, state_d;
  logic                 tx_q, tx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tick;

  rise_detect u_baud_rise (
    .clk     (clk),
    .level_i (baud_in),
    .pulse_o (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_q       <= 1'b1;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        // A tick on the acceptance edge is deliberately ignored: ARMED waits for the next one.
        if (tx_valid) begin
          shreg_d = tx_data;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (tick) begin
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          tx_d      = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = ST_STOP;
          end else begin
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (stop_cnt_q == LAST_STOP) state_d = ST_IDLE;
          else                         stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx_ready = (state_q == ST_IDLE);
  assign busy     = ~tx_ready;
  assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: 8N1 and 8N2 instances fed by a divide-by-16 baud source.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] div_cnt = 4'd0;
  logic       div_baud = 1'b0;
  logic       force_en, force_val;
  logic       baud_in;
  logic       tb_baud_q = 1'b0;
  logic       tick_m;

  logic [7:0] data1, data2;
  logic       valid1, valid2;
  logic       ready1, ready2, tx1, tx2, busy1, busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Upstream clock divider, DIV=16: baud_in period is 32 clk.
  always @(posedge clk) begin
    if (div_cnt == 4'd15) begin
      div_cnt  <= 4'd0;
      div_baud <= ~div_baud;
    end else begin
      div_cnt <= div_cnt + 4'd1;
    end
  end

  assign baud_in = force_en ? force_val : div_baud;

  always @(posedge clk) tb_baud_q <= baud_in;
  assign tick_m = baud_in & ~tb_baud_q;

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .baud_in(baud_in), .tx_data(data1), .tx_valid(valid1),
    .tx_ready(ready1), .tx(tx1), .busy(busy1)
  );

  uart_tx #(.DATA_BITS(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .baud_in(baud_in), .tx_data(data2), .tx_valid(valid2),
    .tx_ready(ready2), .tx(tx2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] outs(input bit sel);
    return sel ? {tx2, ready2, busy2} : {tx1, ready1, busy1};
  endfunction

  // Offer a word at the current sample point, take the acceptance edge, then
  // wait for the start bit and confirm it follows the first tick after acceptance.
  task automatic send(input bit sel, input logic [7:0] data, input bit hold,
                      input logic [7:0] next_data, input string tag, output int fall);
    int tick_idx;
    logic [2:0] o;
    check({tag, " ready_pre"}, 32'(outs(sel)), 32'b110);
    if (sel) begin data2 = data; valid2 = 1'b1; end
    else     begin data1 = data; valid1 = 1'b1; end
    step();
    if (hold) begin
      if (sel) data2 = next_data; else data1 = next_data;
    end else begin
      if (sel) valid2 = 1'b0; else valid1 = 1'b0;
    end
    o = outs(sel);
    check({tag, " accept"}, 32'(o[1:0]), 32'b01);
    tick_idx = -1;
    fall = -1;
    for (int i = 0; i < 70; i++) begin
      o = outs(sel);
      if (o[2] == 1'b0) begin
        fall = i;
        break;
      end
      if (tick_m && tick_idx < 0) tick_idx = i;
      step();
    end
    check({tag, " fall_seen"}, 32'(fall >= 0), 32'd1);
    check({tag, " fall_on_tick"}, 32'(fall), 32'(tick_idx + 1));
  endtask

  // Called at the first sample with the start bit on the line.
  task automatic frame(input bit sel, input logic [7:0] data, input int nstop, input string tag);
    int n;
    int k;
    logic exp_bit;
    n = 32 * (9 + nstop);
    for (int c = 0; c < n; c++) begin
      if (c > 0) step();
      k = c / 32;
      if (k == 0)      exp_bit = 1'b0;
      else if (k <= 8) exp_bit = data[k-1];
      else             exp_bit = 1'b1;
      check($sformatf("%s c%0d", tag, c), 32'(outs(sel)), 32'({exp_bit, 2'b01}));
    end
    step();
    check({tag, " done"}, 32'(outs(sel)), 32'b110);
  endtask

  initial begin
    int fall;
    int lows;
    bit found;

    rst = 1'b1; force_en = 1'b1; force_val = 1'b1;
    valid1 = 1'b0; valid2 = 1'b0; data1 = 8'h00; data2 = 8'h00;
    repeat (3) step();
    check("reset1", 32'(outs(0)), 32'b110);
    check("reset2", 32'(outs(1)), 32'b110);

    // Release with baud_in held high: nothing may move.
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (outs(0) != 3'b110 || outs(1) != 3'b110) lows++;
    end
    check("idle_after_release", 32'(lows), 32'd0);

    // Accepted word must stay armed while baud_in never rises.
    valid1 = 1'b1; data1 = 8'h00;
    step();
    valid1 = 1'b0;
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (outs(0) != 3'b101) lows++;
    end
    check("armed_no_tick", 32'(lows), 32'd0);

    rst = 1'b1;
    step();
    check("reset_armed", 32'(outs(0)), 32'b110);
    rst = 1'b0; force_en = 1'b0;
    repeat (3) step();

    send(0, 8'hA5, 0, 8'h00, "a5", fall);
    if (fall >= 0) frame(0, 8'hA5, 1, "a5");

    // Back-to-back with tx_valid held; data changes mid-frame must not leak in.
    send(0, 8'h00, 1, 8'hFF, "b2b0", fall);
    if (fall >= 0) frame(0, 8'h00, 1, "b2b0");
    send(0, 8'hFF, 0, 8'h00, "b2b1", fall);
    if (fall >= 0) frame(0, 8'hFF, 1, "b2b1");

    // Accept on the same edge as a tick.
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (tick_m) found = 1;
      else step();
    end
    check("tick_align_found", 32'(found), 32'd1);
    send(0, 8'h5A, 0, 8'h00, "coinc", fall);
    check("coinc_latency", 32'(fall), 32'd32);
    if (fall >= 0) frame(0, 8'h5A, 1, "coinc");

    // Reset in the middle of data bit 3 of an all-zero word.
    send(0, 8'h00, 0, 8'h00, "abort", fall);
    repeat (140) step();
    check("abort_mid", 32'(outs(0)), 32'b001);
    rst = 1'b1;
    step();
    check("abort_reset", 32'(outs(0)), 32'b110);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (outs(0) != 3'b110) lows++;
    end
    check("abort_no_resume", 32'(lows), 32'd0);

    send(1, 8'h3C, 0, 8'h00, "stop2", fall);
    if (fall >= 0) frame(1, 8'h3C, 2, "stop2");
    check("dut1_idle_end", 32'(outs(0)), 32'b110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (legal 5..9).
REQ-002 Parameter STOP_BITS, default 1, number of stop-bit intervals per frame (legal 1..2).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock; all state updates on posedge clk.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 baud_in  input  1  divided-clock level from the upstream clock divider, synchronous to clk; one bit interval per rising edge.
REQ-007 tx_data  input  DATA_BITS  byte to transmit; sampled only on acceptance.
REQ-008 tx_valid  input  1  tx_data is valid.
REQ-009 tx_ready  output  1  block can accept a byte; high only in IDLE.
REQ-010 tx  output  1  serial line, registered, idle high.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 Baud tick SHALL be baud_in & ~baud_q, where baud_q is baud_in registered one clk; tick is a one-clk pulse per baud_in rising edge.
REQ-013 Acceptance SHALL occur on a posedge where tx_valid && tx_ready; tx_data is captured into a shift register the same edge.
REQ-014 FSM states: IDLE, ARMED, START, DATA, STOP; all transitions except IDLE->ARMED occur only on tick.
REQ-015 IDLE: tx=1, tx_ready=1; on acceptance -> ARMED.
REQ-016 ARMED: on tick, tx<=0 -> START.
REQ-017 START: on tick, tx<=shreg[0], shift right, bit_cnt<=0 -> DATA.
REQ-018 DATA: on tick, if bit_cnt==DATA_BITS-1 then tx<=1, stop_cnt<=0 -> STOP; else tx<=next bit, bit_cnt+1.
REQ-019 STOP: on tick, if stop_cnt==STOP_BITS-1 -> IDLE, else stop_cnt+1; tx stays 1.
REQ-020 Frame on tx SHALL be: start (0) one interval, data LSB first one interval each, STOP_BITS intervals of 1.
REQ-021 Latency: tx falls on the clk edge of the first tick after the acceptance edge; a tick coincident with acceptance is ignored.
REQ-022 tx_ready SHALL be combinational from state==IDLE; a new byte may be accepted on the same edge STOP->IDLE completes only on the following cycle.
REQ-023 Changes on tx_data/tx_valid while busy SHALL have no effect on the frame in flight.
REQ-024 bit_cnt SHALL be ceil(log2(DATA_BITS)) bits wide and never wrap within a frame.
REQ-025 With upstream divider DIV=N, one bit interval SHALL be exactly 2*N clk cycles.

Reset
REQ-026 While rst=1: state=IDLE, tx=1, tx_ready=1, busy=0, bit_cnt=0, stop_cnt=0, shreg=0.
REQ-027 baud_q SHALL load baud_in during reset, so no spurious tick fires on reset release when baud_in is high.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; tx=1 on the edge after rst and no resumption.

Structure
REQ-029 FSM state encodings SHALL be localparams in a shared uart constants include, reused by the future uart_rx.
REQ-030 The baud edge detector SHALL be a separate sub-module rise_detect (input level, output one-clk pulse, reset-to-input behaviour per REQ-027).
REQ-031 No other sub-modules; the FSM, counters and shift register live in uart_tx.

Verification
REQ-032 Reset with baud_in held 1, release -> no tick, tx=1, tx_ready=1, busy=0 for 100 clk.
REQ-033 Upstream clock_divider DIV=16 drives baud_in; send 0xA5 -> tx low 32 clk from first tick after accept, then 1,0,1,0,0,1,0,1 each 32 clk, stop high 32 clk, tx_ready returns high.
REQ-034 tx_valid held high with 0x00 then 0xFF -> two complete frames, second accepted the cycle after tx_ready reasserts, no bit lost.
REQ-035 Acceptance on same edge as a tick -> tx stays 1, falls exactly 32 clk later on the next tick.
REQ-036 rst pulsed during DATA bit 3 -> tx=1 next clk, busy=0, tx_ready=1, no further frame bits.
REQ-037 STOP_BITS=2, send 0x3C -> stop interval high for 64 clk before tx_ready reasserts.
